mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arb_pkg.sv | 7 +
 rtl/mem_store.sv | 16 +
 rtl/mem_arbiter.sv | 93 +++++++++
 tb/tb_mem_arbiter.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared FSM state type and default geometry for mem_arbiter
package mem_arb_pkg;
  localparam int ADDR_W = 6;
  localparam int DATA_W = 4;
  localparam int DEPTH = 2 ** ADDR_W;
  typedef enum logic [1:0] {CLEAR, IDLE, ACCESS} state_t;
endpackage

// File: rtl/mem_store.sv
// mem_store: DEPTH x DATA_W storage, synchronous write, asynchronous read, no reset
module mem_store #(
  parameter int ADDR_W = mem_arb_pkg::ADDR_W,
  parameter int DATA_W = mem_arb_pkg::DATA_W
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);
  logic [DATA_W-1:0] mem [2**ADDR_W];
  always_ff @(posedge clk) if (we) mem[waddr] <= wdata;
  assign rdata = mem[raddr];
endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: two-requester memory arbiter with clear sweep; ARB_ROUND_ROBIN_EN selects round-robin, else requester 0 wins
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W = mem_arb_pkg::ADDR_W,
  parameter int DATA_W = mem_arb_pkg::DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0,
  input  logic              req1,
  input  logic              we0,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  input  logic              clr,
  output logic              ack0,
  output logic              ack1,
  output logic [DATA_W-1:0] rdata,
  output logic              busy
);
  state_t state;
  logic [ADDR_W-1:0] cnt, cap_addr, maddr;
  logic [DATA_W-1:0] cap_wdata, mem_rd, mwdata;
  logic cap_we, owner, pend, m0, m1, gnt, mwe;
  assign m0 = req0 & ~ack0;
  assign m1 = req1 & ~ack1;
`ifdef ARB_ROUND_ROBIN_EN
  logic last;
  assign gnt = (m0 & m1) ? ~last : m1;
  always_ff @(posedge clk) last <= rst ? 1'b1 : (state == IDLE && !(clr | pend) && (m0 | m1)) ? gnt : last;
`else
  assign gnt = ~m0;
`endif
  assign busy = state == CLEAR;
  assign mwe = ~rst & (state == CLEAR | (state == ACCESS & cap_we));
  assign maddr = state == CLEAR ? cnt : cap_addr;
  assign mwdata = state == CLEAR ? '0 : cap_wdata;
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= CLEAR;
      cnt <= '0;
      ack0 <= 1'b0;
      ack1 <= 1'b0;
      rdata <= '0;
      pend <= 1'b0;
      owner <= 1'b0;
      cap_we <= 1'b0;
      cap_addr <= '0;
      cap_wdata <= '0;
    end else begin
      ack0 <= 1'b0;
      ack1 <= 1'b0;
      case (state)
        CLEAR: begin
          cnt <= cnt == '1 ? cnt : cnt + 1'b1;
          if (cnt == '1) state <= IDLE;
        end
        IDLE: begin
          if (clr | pend) begin
            state <= CLEAR;
            cnt <= '0;
            pend <= 1'b0;
          end else if (m0 | m1) begin
            state <= ACCESS;
            owner <= gnt;
            cap_we <= gnt ? we1 : we0;
            cap_addr <= gnt ? addr1 : addr0;
            cap_wdata <= gnt ? wdata1 : wdata0;
          end
        end
        ACCESS: begin
          state <= IDLE;
          ack0 <= ~owner;
          ack1 <= owner;
          rdata <= cap_we ? cap_wdata : mem_rd;
          pend <= pend | clr;
        end
        default: state <= CLEAR;
      endcase
    end
  end
  mem_store #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_mem (
    .clk(clk),
    .we(mwe),
    .waddr(maddr),
    .wdata(mwdata),
    .raddr(cap_addr),
    .rdata(mem_rd)
  );
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: randomized scoreboard bench for mem_arbiter against a transaction-level model
module tb_mem_arbiter;
`ifdef ARB_ROUND_ROBIN_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif
  typedef struct {
    bit         we;
    logic [5:0] addr;
    logic [3:0] data;
  } tx_t;
  typedef struct {
    int         port;
    logic [3:0] data;
    int         cyc;
  } exp_t;
  logic clk = 1'b0, rst = 1'b1, req0 = 1'b0, req1 = 1'b0, we0 = 1'b0, we1 = 1'b0, clr = 1'b0;
  logic [5:0] addr0 = '0, addr1 = '0;
  logic [3:0] wdata0 = '0, wdata1 = '0;
  logic ack0, ack1, busy;
  logic [3:0] rdata;
  int cyc = 0, checks = 0, errors = 0;
  bit last = 1'b1;
  logic [3:0] mm [64];
  tx_t tx0[$], tx1[$];
  exp_t sb[$];
  mem_arbiter dut (
    .clk(clk), .rst(rst),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .clr(clr), .ack0(ack0), .ack1(ack1), .rdata(rdata), .busy(busy)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string n, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", n, got, exp, cyc);
    end
  endtask
  task automatic mem_clear();
    for (int i = 0; i < 64; i++) mm[i] = '0;
  endtask
  task automatic plan(input bit lat);
    int i0, i1, p;
    bit first;
    tx_t t;
    i0 = 0;
    i1 = 0;
    first = 1'b1;
    p = (tx0.size() > 0 && tx1.size() > 0) ? (RR ? int'(!last) : 0) : (tx0.size() > 0 ? 0 : 1);
    while (i0 < tx0.size() || i1 < tx1.size()) begin
      if (p == 0 && i0 >= tx0.size()) p = 1;
      if (p == 1 && i1 >= tx1.size()) p = 0;
      if (p == 1) begin
        t = tx1[i1];
        i1++;
      end else begin
        t = tx0[i0];
        i0++;
      end
      sb.push_back('{p, t.we ? t.data : mm[t.addr], (first && lat) ? cyc + 2 : -1});
      if (t.we) mm[t.addr] = t.data;
      last = p[0];
      first = 1'b0;
      p = 1 - p;
    end
  endtask
  task automatic drive(input int p);
    int n, w;
    tx_t t;
    n = p ? tx1.size() : tx0.size();
    for (int i = 0; i < n; i++) begin
      t = p ? tx1[i] : tx0[i];
      if (p == 1) begin
        req1 = 1'b1; we1 = t.we; addr1 = t.addr; wdata1 = t.data;
      end else begin
        req0 = 1'b1; we0 = t.we; addr0 = t.addr; wdata0 = t.data;
      end
      w = 0;
      do begin
        @(negedge clk);
        w++;
      end while (!(p ? ack1 : ack0) && w < 400);
      if (w >= 400) begin
        checks++;
        errors++;
        $display("FAIL ack_timeout: port %0d got no ack within %0d cycles", p, w);
      end
    end
    if (p == 1) req1 = 1'b0; else req0 = 1'b0;
  endtask
  task automatic run_chain(input bit lat);
    plan(lat);
    fork
      drive(0);
      drive(1);
    join
    tx0.delete();
    tx1.delete();
    repeat (2) @(negedge clk);
  endtask
  task automatic count_busy(input string n);
    int k;
    k = 0;
    while (busy && k < 300) begin
      k++;
      @(negedge clk);
    end
    chk(n, k, 64);
  endtask
  task automatic rand_round();
    int n0, n1;
    tx_t t;
    n0 = $urandom_range(0, 3);
    n1 = $urandom_range(0, 3);
    if (n0 == 0 && n1 == 0) n0 = 1;
    for (int i = 0; i < n0 + n1; i++) begin
      t.we = 1'($urandom_range(0, 1));
      t.addr = 6'($urandom_range(0, 7));
      t.data = 4'($urandom_range(0, 15));
      if (i < n0) tx0.push_back(t); else tx1.push_back(t);
    end
    run_chain(1'b1);
  endtask
  always @(negedge clk) begin
    exp_t e;
    if (ack0 | ack1) begin
      chk("ack_onehot", {31'd0, ack0 & ack1}, 0);
      chk("ack_not_busy", {31'd0, busy}, 0);
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_ack: ack0=%0b ack1=%0b with no access outstanding", ack0, ack1);
      end else begin
        e = sb.pop_front();
        chk("ack_port", {31'd0, ack1}, e.port);
        chk("rdata", {28'd0, rdata}, {28'd0, e.data});
        if (e.cyc >= 0) chk("latency", cyc, e.cyc);
      end
    end
  end
  initial begin
    mem_clear();
    repeat (3) @(negedge clk);
    chk("rst_ack0", {31'd0, ack0}, 0);
    chk("rst_ack1", {31'd0, ack1}, 0);
    chk("rst_rdata", {28'd0, rdata}, 0);
    chk("rst_busy", {31'd0, busy}, 1);
    rst = 1'b0;
    count_busy("sweep_after_reset");
    tx0.push_back('{1'b0, 6'd0, 4'd0});
    tx0.push_back('{1'b0, 6'd31, 4'd0});
    tx0.push_back('{1'b0, 6'd63, 4'd0});
    run_chain(1'b1);
    tx0.push_back('{1'b1, 6'd4, 4'b1010});
    run_chain(1'b1);
    tx1.push_back('{1'b0, 6'd4, 4'd0});
    run_chain(1'b1);
    tx0.push_back('{1'b1, 6'd10, 4'd3});
    tx0.push_back('{1'b0, 6'd4, 4'd0});
    tx1.push_back('{1'b1, 6'd11, 4'd5});
    tx1.push_back('{1'b0, 6'd10, 4'd0});
    run_chain(1'b1);
    repeat (30) rand_round();
    mm[0] = 4'hF;
    last = 1'b1;
    sb.push_back('{1, 4'hF, cyc + 2});
    req1 = 1'b1; we1 = 1'b1; addr1 = 6'd0; wdata1 = 4'hF;
    @(negedge clk);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    req1 = 1'b0;
    chk("busy_in_ack_cycle", {31'd0, busy}, 0);
    @(negedge clk);
    chk("busy_after_pending_clr", {31'd0, busy}, 1);
    count_busy("sweep_after_pending_clr");
    mem_clear();
    tx0.push_back('{1'b0, 6'd0, 4'd0});
    run_chain(1'b1);
    tx0.push_back('{1'b1, 6'd9, 4'b0110});
    run_chain(1'b1);
    clr = 1'b1;
    mem_clear();
    tx0.push_back('{1'b0, 6'd9, 4'd0});
    plan(1'b0);
    fork
      drive(0);
      begin
        @(negedge clk);
        clr = 1'b0;
        chk("busy_after_clr", {31'd0, busy}, 1);
        fork
          count_busy("sweep_ignores_clr");
          begin
            repeat (10) @(negedge clk);
            clr = 1'b1;
            @(negedge clk);
            clr = 1'b0;
          end
        join
      end
    join
    tx0.delete();
    repeat (2) @(negedge clk);
    req0 = 1'b1; we0 = 1'b1; addr0 = 6'd5; wdata0 = 4'd7;
    @(negedge clk);
    rst = 1'b1;
    req0 = 1'b0;
    @(negedge clk);
    chk("rst_abort_ack0", {31'd0, ack0}, 0);
    chk("rst_abort_busy", {31'd0, busy}, 1);
    rst = 1'b0;
    mem_clear();
    last = 1'b1;
    count_busy("sweep_after_abort");
    tx0.push_back('{1'b0, 6'd5, 4'd0});
    run_chain(1'b1);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    mem_clear();
    repeat (20) @(negedge clk);
    rst = 1'b1;
    last = 1'b1;
    @(negedge clk);
    chk("busy_in_mid_sweep_rst", {31'd0, busy}, 1);
    chk("no_ack_in_mid_sweep_rst", {30'd0, ack0, ack1}, 0);
    rst = 1'b0;
    count_busy("sweep_restart");
    repeat (5) rand_round();
    chk("scoreboard_empty", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
